// File: rtl/uart_rx_byte_if.sv
// Byte handoff bundle between the UART receiver and its consumer.
// The receiver drives data, valid and the status pulses; the consumer drives ready.
interface uart_rx_byte_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1-style serial receiver with a one-entry valid/ready output buffer.
// Pulses frame_err on a low stop bit and overrun when a finished byte is dropped.
module uart_rx_byte #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           uart_rx,
  uart_rx_byte_if.master rx_bus
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rx_s;
  logic w_start_edge;
  logic w_bit_end;
  logic w_stop_good;
  logic w_stop_bad;

  assign w_rx_s       = r_sync2;
  assign w_start_edge = r_prev & ~r_sync2;
  assign w_bit_end    = (r_cnt == CNT_LAST);
  assign w_stop_good  = (r_state == S_STOP) & w_bit_end & w_rx_s;
  assign w_stop_bad   = (r_state == S_STOP) & w_bit_end & ~w_rx_s;

  // Flops reset high so the idle line never looks like a start edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start_edge) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          // Mid-start resample rejects glitches shorter than half a bit.
          if (r_cnt == CNT_MID) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == IDX_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A same-cycle accept frees the slot, so a completing byte may replace it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_stop_good) begin
        if (!r_valid || rx_bus.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_bus.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data   = r_data;
  assign rx_bus.rx_valid  = r_valid;
  assign rx_bus.frame_err = r_frame_err;
  assign rx_bus.overrun   = r_overrun;

endmodule
